frog_move_controller: RTL and testbench
=======================================

Name: frog_move_controller

Overview:
- Sequences the frog's position for the Frogger display path.
- Turns button presses into single grid-step moves, applied only on frame boundaries, so frog_x/frog_y never change mid-scan.
- Owns the frog life cycle: alive, goal reached, dying (with blink), respawn and game over.
- Drives the frog_x/frog_y inputs of the frog square drawer, plus the lives, score and status outputs.

Parameters:
- GRID_SIZE, 32: step size in pixels for both axes.
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- START_X, 320: respawn x, a multiple of GRID_SIZE.
- START_Y, 448: respawn y, a multiple of GRID_SIZE.
- COOLDOWN_FRAMES, 8: frames after a move during which new presses are ignored.
- DEATH_FRAMES, 60: frames spent in DYING.
- LIVES_INIT, 3: lives after reset or restart (1..7).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- btn_up / btn_down / btn_left / btn_right, input, 1 each: debounced, clk-synchronous button levels.
- frame_tick, input, 1: one-cycle pulse at the start of vertical blanking.
- collision, input, 1: frog overlaps a hazard (level); sampled only on frame_tick.
- frog_x, output, 10: frog left edge in pixels.
- frog_y, output, 10: frog top edge in pixels.
- frog_visible, output, 1: gates frog_square in the pixel mixer.
- lives, output, 3: remaining lives.
- score, output, 8: goals reached, saturating.
- game_over, output, 1: high in GAME_OVER.
- move_pulse, output, 1: one-cycle pulse when a move is applied.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=ALIVE, frog_x=START_X, frog_y=START_Y, frog_visible=1, lives=LIVES_INIT, score=0, game_over=0, move_pulse=0, cooldown=0, pending=none, all button edge registers cleared (a button held through reset does not count as a press).
- Edge detect: a press is a 0->1 transition of a registered button level.
- Pending move latch: in ALIVE with cooldown==0 and pending==none, a press latches a direction.
  - Simultaneous presses resolve by priority up > down > left > right.
  - Presses are ignored while a move is pending, during cooldown, or in any other state.
- States: ALIVE, GOAL, DYING, GAME_OVER. All transitions and position updates occur only on the clk edge where frame_tick=1.
- ALIVE on frame_tick, evaluated in this order:
  1. collision=1: enter DYING, clear pending, death counter=0, lives decrements by 1. No move is applied that frame.
  2. Otherwise, if pending is legal, apply it: ±GRID_SIZE on the axis, move_pulse=1 for that cycle, cooldown=COOLDOWN_FRAMES, pending cleared.
  3. Legality:
     - up: frog_y >= GRID_SIZE.
     - down: frog_y + 2*GRID_SIZE <= SCREEN_H.
     - left: frog_x >= GRID_SIZE.
     - right: frog_x + 2*GRID_SIZE <= SCREEN_W.
     - An illegal pending move is consumed with no position change, no pulse and no cooldown.
  4. If the applied move yields frog_y==0, go to GOAL.
  5. If no move was applied and cooldown>0, cooldown decrements by 1.
- GOAL: on the next frame_tick:
  - score increments, saturating at 255.
  - frog returns to START_X/START_Y.
  - state returns to ALIVE with cooldown=COOLDOWN_FRAMES.
  - collision is ignored in GOAL.
- DYING:
  - frog_visible = ~death_counter[3], i.e. blink with an 8-frame half-period.
  - The death counter increments each frame_tick.
  - When the counter reaches DEATH_FRAMES-1, on that frame_tick:
    - lives==0 -> GAME_OVER with frog_visible=0.
    - Otherwise -> respawn at START_X/START_Y, state ALIVE, frog_visible=1, cooldown=COOLDOWN_FRAMES.
  - Collision is ignored during DYING.
- GAME_OVER:
  - game_over=1; position is held.
  - Any press, edge detected with no frame_tick needed, restarts on that clk edge: lives=LIVES_INIT, score=0, frog at start, frog_visible=1, state ALIVE, game_over=0, cooldown=COOLDOWN_FRAMES.
- Arithmetic: position arithmetic is 11 bits internally; legality is checked before update, so no wrap-around is possible. The lives decrement occurs only when lives>0.
- Reset asserted mid-DYING or mid-cooldown returns to the reset values in the next cycle; counters do not carry over.

Test Plan:
- Reset with btn_up held, then release and press once; frame_tick -> no move from the held button; after the press, frog_y 448->416, one move_pulse, frog_x unchanged at 320.
- Press right, then 3 more right presses within the next 8 frames -> only the first applies (frog_x=352); a press after 8 further frame_ticks moves to 384.
- Place the frog at x=0 and press left; separately, at y=448 press down -> no change, no move_pulse, no cooldown (an immediate right press is honoured on the next frame).
- Raise collision and a pending up on the same frame_tick -> lives 3->2, position unchanged, DYING with frog_visible low on frames 8-15; after 60 frames, frog at (320,448) and visible.
- Step up 14 times to y=0 -> GOAL; next frame_tick gives score=1 and the frog at start; collision asserted during GOAL has no effect.
- Die 3 times -> lives=0, game_over=1 after the third DYING; press left with no frame_tick -> lives=3, score=0, game_over=0 on the next clk edge.

Source files
------------

// File: rtl/frog_move_controller.sv
// Frog position sequencer for the Frogger display path: turns button presses into
// frame-aligned grid steps and runs the alive / goal / dying / game-over life cycle.
module frog_move_controller #(
   parameter int GRID_SIZE       = 32,
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int START_X         = 320,
   parameter int START_Y         = 448,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int DEATH_FRAMES    = 60,
   parameter int LIVES_INIT      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       frame_tick,
   input  logic       collision,
   output logic [9:0] frog_x,
   output logic [9:0] frog_y,
   output logic       frog_visible,
   output logic [2:0] lives,
   output logic [7:0] score,
   output logic       game_over,
   output logic       move_pulse
);

   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
   localparam int DC_W = ($clog2(DEATH_FRAMES) > 4) ? $clog2(DEATH_FRAMES) : 4;

   localparam logic [9:0]  GRID_10    = 10'(GRID_SIZE);
   localparam logic [10:0] GRID_11    = 11'(GRID_SIZE);
   localparam logic [10:0] GRID2_11   = 11'(2 * GRID_SIZE);
   localparam logic [10:0] SCR_W_11   = 11'(SCREEN_W);
   localparam logic [10:0] SCR_H_11   = 11'(SCREEN_H);
   localparam logic [9:0]  START_X_10 = 10'(START_X);
   localparam logic [9:0]  START_Y_10 = 10'(START_Y);
   localparam logic [CD_W-1:0] COOL_INIT  = CD_W'(COOLDOWN_FRAMES);
   localparam logic [DC_W-1:0] DEATH_LAST = DC_W'(DEATH_FRAMES - 1);
   localparam logic [2:0]  LIVES_RST  = 3'(LIVES_INIT);

   typedef enum logic [1:0] {
      ST_ALIVE,
      ST_GOAL,
      ST_DYING,
      ST_GAME_OVER
   } state_e;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   // Button edge detection, bit order {up, down, left, right}
   logic [3:0] btn_now;
   logic [3:0] btn_lvl_q;
   logic [3:0] btn_prev_q;
   logic       btn_armed_q;
   logic [3:0] press;
   logic       any_press;
   dir_e       press_dir;

   assign btn_now = {btn_up, btn_down, btn_left, btn_right};

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_lvl_q   <= '0;
         btn_prev_q  <= '0;
         btn_armed_q <= 1'b0;
      end else if (!btn_armed_q) begin
         // First cycle after reset: seed both stages so a held button is not a press.
         btn_lvl_q   <= btn_now;
         btn_prev_q  <= btn_now;
         btn_armed_q <= 1'b1;
      end else begin
         btn_lvl_q   <= btn_now;
         btn_prev_q  <= btn_lvl_q;
      end
   end

   assign press     = btn_lvl_q & ~btn_prev_q;
   assign any_press = |press;

   always_comb begin
      press_dir = DIR_NONE;
      if (press[3])      press_dir = DIR_UP;
      else if (press[2]) press_dir = DIR_DOWN;
      else if (press[1]) press_dir = DIR_LEFT;
      else if (press[0]) press_dir = DIR_RIGHT;
   end

   // Main state
   state_e          state_q,      state_d;
   dir_e            pending_q,    pending_d;
   logic [9:0]      x_q,          x_d;
   logic [9:0]      y_q,          y_d;
   logic [2:0]      lives_q,      lives_d;
   logic [7:0]      score_q,      score_d;
   logic [CD_W-1:0] cool_q,       cool_d;
   logic [DC_W-1:0] death_q,      death_d;
   logic            move_pulse_q, move_pulse_d;

   // Target of the pending move and whether it stays on screen (11-bit checks)
   logic [9:0]  tgt_x;
   logic [9:0]  tgt_y;
   logic        tgt_legal;
   logic [10:0] x_ext;
   logic [10:0] y_ext;

   assign x_ext = {1'b0, x_q};
   assign y_ext = {1'b0, y_q};

   // NOTE: every always_comb output gets a default before any branch; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      tgt_x     = x_q;
      tgt_y     = y_q;
      tgt_legal = 1'b0;
      unique case (pending_q)
         DIR_UP: begin
            tgt_legal = (y_ext >= GRID_11);
            tgt_y     = y_q - GRID_10;
         end
         DIR_DOWN: begin
            tgt_legal = (y_ext + GRID2_11 <= SCR_H_11);
            tgt_y     = y_q + GRID_10;
         end
         DIR_LEFT: begin
            tgt_legal = (x_ext >= GRID_11);
            tgt_x     = x_q - GRID_10;
         end
         DIR_RIGHT: begin
            tgt_legal = (x_ext + GRID2_11 <= SCR_W_11);
            tgt_x     = x_q + GRID_10;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      x_d          = x_q;
      y_d          = y_q;
      lives_d      = lives_q;
      score_d      = score_q;
      cool_d       = cool_q;
      death_d      = death_q;
      move_pulse_d = 1'b0;

      unique case (state_q)
         ST_ALIVE: begin
            if (cool_q == '0 && pending_q == DIR_NONE && any_press) begin
               pending_d = press_dir;
            end
            if (frame_tick) begin
               if (collision) begin
                  state_d   = ST_DYING;
                  pending_d = DIR_NONE;
                  death_d   = '0;
                  if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
               end else if (pending_q != DIR_NONE) begin
                  pending_d = DIR_NONE;
                  if (tgt_legal) begin
                     x_d          = tgt_x;
                     y_d          = tgt_y;
                     move_pulse_d = 1'b1;
                     cool_d       = COOL_INIT;
                     if (tgt_y == 10'd0) state_d = ST_GOAL;
                  end else if (cool_q != '0) begin
                     cool_d = cool_q - CD_W'(1);
                  end
               end else if (cool_q != '0) begin
                  cool_d = cool_q - CD_W'(1);
               end
            end
         end

         ST_GOAL: begin
            if (frame_tick) begin
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
               x_d       = START_X_10;
               y_d       = START_Y_10;
               state_d   = ST_ALIVE;
               cool_d    = COOL_INIT;
               pending_d = DIR_NONE;
            end
         end

         ST_DYING: begin
            if (frame_tick) begin
               if (death_q == DEATH_LAST) begin
                  if (lives_q == 3'd0) begin
                     state_d = ST_GAME_OVER;
                  end else begin
                     state_d   = ST_ALIVE;
                     x_d       = START_X_10;
                     y_d       = START_Y_10;
                     cool_d    = COOL_INIT;
                     pending_d = DIR_NONE;
                  end
               end else begin
                  death_d = death_q + DC_W'(1);
               end
            end
         end

         ST_GAME_OVER: begin
            // Restart is edge driven and does not wait for a frame boundary.
            if (any_press) begin
               state_d   = ST_ALIVE;
               lives_d   = LIVES_RST;
               score_d   = 8'd0;
               x_d       = START_X_10;
               y_d       = START_Y_10;
               cool_d    = COOL_INIT;
               pending_d = DIR_NONE;
               death_d   = '0;
            end
         end

         default: state_d = ST_ALIVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ALIVE;
         pending_q    <= DIR_NONE;
         x_q          <= START_X_10;
         y_q          <= START_Y_10;
         lives_q      <= LIVES_RST;
         score_q      <= 8'd0;
         cool_q       <= '0;
         death_q      <= '0;
         move_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         x_q          <= x_d;
         y_q          <= y_d;
         lives_q      <= lives_d;
         score_q      <= score_d;
         cool_q       <= cool_d;
         death_q      <= death_d;
         move_pulse_q <= move_pulse_d;
      end
   end

   always_comb begin
      frog_visible = 1'b1;
      unique case (state_q)
         ST_DYING:     frog_visible = ~death_q[3];
         ST_GAME_OVER: frog_visible = 1'b0;
         default:      frog_visible = 1'b1;
      endcase
   end

   assign frog_x     = x_q;
   assign frog_y     = y_q;
   assign lives      = lives_q;
   assign score      = score_q;
   assign game_over  = (state_q == ST_GAME_OVER);
   assign move_pulse = move_pulse_q;

endmodule

// File: tb/tb_frog_move_controller.sv
// Directed self-checking bench for frog_move_controller: moves, cooldown, edges,
// death/blink/respawn, goal scoring and game-over restart.
module tb_frog_move_controller;

   localparam int UP    = 0;
   localparam int DOWN  = 1;
   localparam int LEFT  = 2;
   localparam int RIGHT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, btn_left, btn_right;
   logic       frame_tick;
   logic       collision;
   logic [9:0] frog_x, frog_y;
   logic       frog_visible;
   logic [2:0] lives;
   logic [7:0] score;
   logic       game_over;
   logic       move_pulse;

   int n_tests   = 0;
   int n_fail    = 0;
   int pulse_cnt = 0;

   always #5 clk = ~clk;

   frog_move_controller dut (
      .clk          (clk),
      .reset        (reset),
      .btn_up       (btn_up),
      .btn_down     (btn_down),
      .btn_left     (btn_left),
      .btn_right    (btn_right),
      .frame_tick   (frame_tick),
      .collision    (collision),
      .frog_x       (frog_x),
      .frog_y       (frog_y),
      .frog_visible (frog_visible),
      .lives        (lives),
      .score        (score),
      .game_over    (game_over),
      .move_pulse   (move_pulse)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clk edge with frame_tick high; move_pulse is sampled in the following cycle.
   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (move_pulse === 1'b1) pulse_cnt++;
   endtask

   task automatic set_btn(input int dir, input logic val);
      case (dir)
         UP:      btn_up    = val;
         DOWN:    btn_down  = val;
         LEFT:    btn_left  = val;
         default: btn_right = val;
      endcase
   endtask

   task automatic press(input int dir);
      @(negedge clk);
      set_btn(dir, 1'b1);
      repeat (2) @(negedge clk);
      set_btn(dir, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   task automatic move_settle(input int dir);
      press(dir);
      tick();
      repeat (8) tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic die();
      collision = 1'b1;
      tick();
      collision = 1'b0;
      repeat (60) tick();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      btn_up     = 1'b1;
      btn_down   = 1'b0;
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      frame_tick = 1'b0;
      collision  = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_x", frog_x, 320);
      check("rst_y", frog_y, 448);
      check("rst_visible", frog_visible, 1);
      check("rst_lives", lives, 3);
      check("rst_score", score, 0);
      check("rst_game_over", game_over, 0);
      check("rst_move_pulse", move_pulse, 0);

      // Button held through reset must not move the frog
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tick();
      check("held_up_y", frog_y, 448);
      check("held_up_pulses", pulse_cnt, 0);
      btn_up = 1'b0;
      repeat (3) @(negedge clk);
      press(UP);
      tick();
      check("up_y", frog_y, 416);
      check("up_x", frog_x, 320);
      check("up_pulses", pulse_cnt, 1);

      // Cooldown: extra presses inside 8 frames are dropped
      repeat (8) tick();
      press(RIGHT);
      tick();
      check("right1_x", frog_x, 352);
      repeat (3) begin
         press(RIGHT);
         tick();
      end
      check("cooldown_x", frog_x, 352);
      check("cooldown_pulses", pulse_cnt, 2);
      repeat (5) tick();
      press(RIGHT);
      tick();
      check("right2_x", frog_x, 384);
      check("right2_pulses", pulse_cnt, 3);

      // Left edge: illegal move consumed with no cooldown
      repeat (8) tick();
      repeat (12) move_settle(LEFT);
      check("walk_left_x", frog_x, 0);
      check("walk_left_pulses", pulse_cnt, 15);
      press(LEFT);
      tick();
      check("left_edge_x", frog_x, 0);
      check("left_edge_pulses", pulse_cnt, 15);
      press(RIGHT);
      tick();
      check("after_left_edge_x", frog_x, 32);
      check("after_left_edge_pulses", pulse_cnt, 16);

      // Bottom edge
      do_reset();
      press(DOWN);
      tick();
      check("bottom_edge_y", frog_y, 448);
      check("bottom_edge_pulses", pulse_cnt, 16);
      press(RIGHT);
      tick();
      check("after_bottom_edge_x", frog_x, 352);
      check("after_bottom_edge_pulses", pulse_cnt, 17);

      // Collision beats a pending move; blink and respawn
      do_reset();
      press(UP);
      collision = 1'b1;
      tick();
      check("hit_lives", lives, 2);
      check("hit_y", frog_y, 448);
      check("hit_x", frog_x, 320);
      check("hit_pulses", pulse_cnt, 17);
      check("hit_visible_f0", frog_visible, 1);
      repeat (8) tick();
      collision = 1'b0;
      check("dying_lives_hold", lives, 2);
      check("dying_visible_f8", frog_visible, 0);
      repeat (7) tick();
      check("dying_visible_f15", frog_visible, 0);
      tick();
      check("dying_visible_f16", frog_visible, 1);
      repeat (43) tick();
      check("dying_visible_f59", frog_visible, 0);
      tick();
      check("respawn_visible", frog_visible, 1);
      check("respawn_x", frog_x, 320);
      check("respawn_y", frog_y, 448);
      check("respawn_lives", lives, 2);
      check("respawn_game_over", game_over, 0);
      press(UP);
      tick();
      check("respawn_cooldown_y", frog_y, 448);

      // Goal: 14 steps up, then score on the following frame
      do_reset();
      repeat (13) move_settle(UP);
      check("goal_approach_y", frog_y, 32);
      press(UP);
      tick();
      check("goal_y", frog_y, 0);
      check("goal_score_before", score, 0);
      collision = 1'b1;
      tick();
      collision = 1'b0;
      check("goal_score", score, 1);
      check("goal_return_x", frog_x, 320);
      check("goal_return_y", frog_y, 448);
      check("goal_lives", lives, 3);

      // Three deaths to game over, then restart on a press without frame_tick
      die();
      check("die1_lives", lives, 2);
      die();
      check("die2_lives", lives, 1);
      check("die2_game_over", game_over, 0);
      die();
      check("die3_lives", lives, 0);
      check("die3_game_over", game_over, 1);
      check("die3_visible", frog_visible, 0);
      check("die3_score", score, 1);
      tick();
      check("game_over_hold", game_over, 1);
      @(negedge clk);
      btn_left = 1'b1;
      @(negedge clk);
      check("restart_not_yet", game_over, 1);
      @(negedge clk);
      btn_left = 1'b0;
      check("restart_lives", lives, 3);
      check("restart_score", score, 0);
      check("restart_game_over", game_over, 0);
      check("restart_visible", frog_visible, 1);
      check("restart_x", frog_x, 320);
      check("restart_y", frog_y, 448);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
